// File: rtl/hazard_control_unit.sv
// Load-use and memory-wait hazard controller for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_CNT_EN to add the saturating StallCycles performance counter.
module hazard_control_unit #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rs_ID,
  input  logic [ADDR_W-1:0] Rt_ID,
  input  logic              UsesRs_ID,
  input  logic              UsesRt_ID,
  input  logic [ADDR_W-1:0] Rt_EX,
  input  logic [1:0]        MemToReg_EX,
  input  logic              BranchTaken_ID,
  input  logic              MemBusy_MEM,
  output logic              Stall_IF,
  output logic              Stall_ID,
  output logic              Stall_EX,
  output logic              Stall_MEM,
  output logic              Flush_IF,
  output logic              Flush_EX,
  output logic              Flush_WB
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       StallCycles
`endif
);

  typedef enum logic {
    RUN,
    LOAD_STALL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             loadInEx;
  logic             rsMatch;
  logic             rtMatch;
  logic             loadUseHit;

  // Register 0 is hard-wired, so a load targeting it can never create a dependency.
  assign loadInEx   = (MemToReg_EX == 2'b01) && (Rt_EX != '0);
  assign rsMatch    = UsesRs_ID && (Rs_ID == Rt_EX);
  assign rtMatch    = UsesRt_ID && (Rt_ID == Rt_EX);
  assign loadUseHit = loadInEx && (rsMatch || rtMatch);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    Stall_IF  = 1'b0;
    Stall_ID  = 1'b0;
    Stall_EX  = 1'b0;
    Stall_MEM = 1'b0;
    Flush_EX  = 1'b0;
    Flush_WB  = 1'b0;

    // A busy memory freezes the whole front of the pipe and the FSM with it.
    if (MemBusy_MEM) begin
      Stall_IF  = 1'b1;
      Stall_ID  = 1'b1;
      Stall_EX  = 1'b1;
      Stall_MEM = 1'b1;
      Flush_WB  = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (loadUseHit) begin
            Stall_IF = 1'b1;
            Stall_ID = 1'b1;
            Flush_EX = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
          end
        end
        LOAD_STALL: begin
          Stall_IF = 1'b1;
          Stall_ID = 1'b1;
          Flush_EX = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end

    // A branch resolved while ID is held is simply seen again once ID moves.
    Flush_IF = BranchTaken_ID && !Stall_ID;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCycles_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCycles_q <= '0;
    end else if (Stall_ID && (stallCycles_q != 32'hFFFF_FFFF)) begin
      stallCycles_q <= stallCycles_q + 32'd1;
    end
  end

  assign StallCycles = stallCycles_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench: two DUTs (LOAD_LAT=1 and 3) share stimulus and are
// compared every cycle against a remaining-stall-count model, plus literal checks.
module tb_hazard_control_unit;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  localparam logic [6:0] IDLE  = 7'b0000000;
  localparam logic [6:0] STALL = 7'b1100010;
  localparam logic [6:0] BUSY  = 7'b1111001;
  localparam logic [6:0] BRFL  = 7'b0000100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] Rs_ID = '0, Rt_ID = '0, Rt_EX = '0;
  logic       UsesRs_ID = 1'b0, UsesRt_ID = 1'b0;
  logic [1:0] MemToReg_EX = '0;
  logic       BranchTaken_ID = 1'b0, MemBusy_MEM = 1'b0;

  // Output bundles: {Stall_IF, Stall_ID, Stall_EX, Stall_MEM, Flush_IF, Flush_EX, Flush_WB}
  wire [6:0]  outA, outB;

  int checks = 0;
  int errors = 0;

  int remA = 0, remB = 0, nextRemA = 0, nextRemB = 0;
  logic [6:0] expA = '0, expB = '0;
  longint perfA = 0, perfB = 0;

`ifdef HAZARD_PERF_CNT_EN
  wire [31:0] stallCyclesA, stallCyclesB;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(.ADDR_W(5), .LOAD_LAT(LAT_A), .CNT_W(4)) dutA (
    .clk(clk), .reset(reset),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID),
    .Rt_EX(Rt_EX), .MemToReg_EX(MemToReg_EX),
    .BranchTaken_ID(BranchTaken_ID), .MemBusy_MEM(MemBusy_MEM),
    .Stall_IF(outA[6]), .Stall_ID(outA[5]), .Stall_EX(outA[4]), .Stall_MEM(outA[3]),
    .Flush_IF(outA[2]), .Flush_EX(outA[1]), .Flush_WB(outA[0])
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(stallCyclesA)
`endif
  );

  hazard_control_unit #(.ADDR_W(5), .LOAD_LAT(LAT_B), .CNT_W(4)) dutB (
    .clk(clk), .reset(reset),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID),
    .Rt_EX(Rt_EX), .MemToReg_EX(MemToReg_EX),
    .BranchTaken_ID(BranchTaken_ID), .MemBusy_MEM(MemBusy_MEM),
    .Stall_IF(outB[6]), .Stall_ID(outB[5]), .Stall_EX(outB[4]), .Stall_MEM(outB[3]),
    .Flush_IF(outB[2]), .Flush_EX(outB[1]), .Flush_WB(outB[0])
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(stallCyclesB)
`endif
  );

  // Model: "rem" is how many more stall cycles are owed after the current one.
  task automatic computeExpected(input int lat, input int rem,
                                 output logic [6:0] exp, output int nextRem);
    bit hit;
    hit = (MemToReg_EX == 2'b01) && (Rt_EX != 0) &&
          ((UsesRs_ID && (Rs_ID == Rt_EX)) || (UsesRt_ID && (Rt_ID == Rt_EX)));
    exp = IDLE;
    nextRem = rem;
    if (MemBusy_MEM) begin
      exp = BUSY;
    end else if (rem > 0) begin
      exp = STALL;
      nextRem = rem - 1;
    end else if (hit) begin
      exp = STALL;
      nextRem = lat - 1;
    end
    if (BranchTaken_ID && !exp[5]) exp[2] = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, in the middle of the cycle.
  always @(negedge clk) begin
    computeExpected(LAT_A, remA, expA, nextRemA);
    computeExpected(LAT_B, remB, expB, nextRemB);
    checkOutput("modelA", outA, expA);
    checkOutput("modelB", outB, expB);
`ifdef HAZARD_PERF_CNT_EN
    checkCount("perfA", longint'(stallCyclesA), perfA);
    checkCount("perfB", longint'(stallCyclesB), perfB);
`endif
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      remA = 0;
      remB = 0;
      perfA = 0;
      perfB = 0;
    end else begin
      remA = nextRemA;
      remB = nextRemB;
      if (expA[5] && perfA < 64'hFFFF_FFFF) perfA = perfA + 1;
      if (expB[5] && perfB < 64'hFFFF_FFFF) perfB = perfB + 1;
    end
  end

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               input logic [4:0] rtex, input logic [1:0] m2r,
                               input logic br, input logic busy);
    @(posedge clk);
    #1;
    Rs_ID = rs;  Rt_ID = rt;  UsesRs_ID = urs;  UsesRt_ID = urt;
    Rt_EX = rtex;  MemToReg_EX = m2r;  BranchTaken_ID = br;  MemBusy_MEM = busy;
  endtask

  task automatic stepCheck(input string name,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt,
                           input logic [4:0] rtex, input logic [1:0] m2r,
                           input logic br, input logic busy,
                           input logic [6:0] eA, input logic [6:0] eB);
    applyStimulus(rs, rt, urs, urt, rtex, m2r, br, busy);
    @(negedge clk);
    #1;
    checkOutput({name, "_A"}, outA, eA);
    checkOutput({name, "_B"}, outB, eB);
  endtask

  initial begin
    $display("[TB] start");
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_A", outA, IDLE);
    checkOutput("reset_B", outB, IDLE);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Load into r5 consumed through Rs; Rt_EX disappears after the detect cycle.
    stepCheck("hit1",   5, 0, 1, 0, 5, 2'b01, 0, 0, STALL, STALL);
    stepCheck("hit2",   5, 0, 1, 0, 0, 2'b00, 0, 0, IDLE,  STALL);
    stepCheck("hit3",   5, 0, 1, 0, 0, 2'b00, 0, 0, IDLE,  STALL);
    stepCheck("hit4",   5, 0, 1, 0, 0, 2'b00, 0, 0, IDLE,  IDLE);
    stepCheck("r0",     0, 0, 1, 1, 0, 2'b01, 0, 0, IDLE,  IDLE);
    stepCheck("noUse",  7, 7, 0, 0, 7, 2'b01, 0, 0, IDLE,  IDLE);
    stepCheck("rtHit",  1, 9, 0, 1, 9, 2'b01, 0, 0, STALL, STALL);
    stepCheck("tail1",  0, 0, 0, 0, 0, 2'b00, 0, 0, IDLE,  STALL);
    stepCheck("tail2",  0, 0, 0, 0, 0, 2'b00, 0, 0, IDLE,  STALL);

    // Busy memory in the middle of the B stall stretches it to five cycles.
    stepCheck("bHit",   3, 0, 1, 0, 3, 2'b01, 0, 0, STALL, STALL);
    stepCheck("busy1",  0, 0, 0, 0, 0, 2'b00, 0, 1, BUSY,  BUSY);
    stepCheck("busy2",  0, 0, 0, 0, 0, 2'b00, 1, 1, BUSY,  BUSY);
    stepCheck("post1",  0, 0, 0, 0, 0, 2'b00, 0, 0, IDLE,  STALL);
    stepCheck("post2",  0, 0, 0, 0, 0, 2'b00, 0, 0, IDLE,  STALL);
    stepCheck("post3",  0, 0, 0, 0, 0, 2'b00, 0, 0, IDLE,  IDLE);

    // Taken branch is gated while ID is stalled.
    stepCheck("br1",    4, 0, 1, 0, 4, 2'b01, 1, 0, STALL, STALL);
    stepCheck("br2",    0, 0, 0, 0, 0, 2'b00, 1, 0, BRFL,  STALL);
    stepCheck("br3",    0, 0, 0, 0, 0, 2'b00, 1, 0, BRFL,  STALL);
    stepCheck("br4",    0, 0, 0, 0, 0, 2'b00, 1, 0, BRFL,  BRFL);
    stepCheck("br5",    0, 0, 0, 0, 0, 2'b00, 0, 0, IDLE,  IDLE);

    // Asynchronous reset during the second LOAD_STALL cycle of B.
    stepCheck("rs1",    6, 0, 1, 0, 6, 2'b01, 0, 0, STALL, STALL);
    stepCheck("rs2",    0, 0, 0, 0, 0, 2'b00, 0, 0, IDLE,  STALL);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0);
    #1;
    checkOutput("rs3_B", outB, STALL);
    reset = 1'b0;
    #1;
    checkOutput("rsLow_A", outA, IDLE);
    checkOutput("rsLow_B", outB, IDLE);
`ifdef HAZARD_PERF_CNT_EN
    checkCount("perfReset_B", longint'(stallCyclesB), 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    stepCheck("fresh1", 8, 0, 1, 0, 8, 2'b01, 0, 0, STALL, STALL);
    stepCheck("fresh2", 0, 0, 0, 0, 0, 2'b00, 0, 0, IDLE,  STALL);
    stepCheck("fresh3", 0, 0, 0, 0, 0, 2'b00, 0, 0, IDLE,  STALL);
    stepCheck("fresh4", 0, 0, 0, 0, 0, 2'b00, 0, 0, IDLE,  IDLE);
`ifdef HAZARD_PERF_CNT_EN
    checkCount("perfFresh_A", longint'(stallCyclesA), 1);
    checkCount("perfFresh_B", longint'(stallCyclesB), 3);
`endif

    // Randomised phase, small register range so hits are frequent.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      reset          = ($urandom_range(0, 99) != 0);
      Rs_ID          = 5'($urandom_range(0, 3));
      Rt_ID          = 5'($urandom_range(0, 3));
      Rt_EX          = 5'($urandom_range(0, 3));
      UsesRs_ID      = ($urandom_range(0, 3) != 0);
      UsesRt_ID      = ($urandom_range(0, 1) != 0);
      MemToReg_EX    = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
      BranchTaken_ID = ($urandom_range(0, 2) == 0);
      MemBusy_MEM    = ($urandom_range(0, 5) == 0);
    end

    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
